sentence_editor_ctrl_p: RTL

- Parametrised successor to the fixed 8-word × 4-character sentence editor.
- Holds an editable sentence of NUM_WORDS words, each CHARS_PER_WORD PS/2 scan-code characters, plus a per-word cursor.
- Accepts validated single-cycle key strobes and button pulses, and drives the 7-seg character bus (with a blinking cursor glyph) and the word-select LEDs.
- Adds over the previous generation: one-action-per-cycle priority, bounded or wrapping navigation, a dirty flag, and a forward-delete key.

---
 rtl/sentence_editor_ctrl_p.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sentence_editor_ctrl_p.sv
// Parametrised sentence editor: NUM_WORDS words of CHARS_PER_WORD PS/2 codes with per-word cursors.
// Define SENTENCE_EDITOR_WRAP_EN to make next/prev wrap at the ends instead of saturating.
module sentence_editor_ctrl_p #(
    parameter int unsigned NUM_WORDS      = 8,
    parameter int unsigned CHARS_PER_WORD = 4,
    parameter int unsigned BLINK_COUNTS   = 40_000_000,
    parameter logic [7:0]  CURSOR_CODE    = 8'h5D
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       enable,
    input  logic                                       key_valid,
    input  logic [7:0]                                 key_code,
    input  logic                                       prev_word,
    input  logic                                       next_word,
    input  logic                                       save,
    input  logic                                       load,
    input  logic [NUM_WORDS*8*CHARS_PER_WORD-1:0]      preset_sentence,
    input  logic [NUM_WORDS*$clog2(CHARS_PER_WORD+1)-1:0] preset_cursors,
    output logic [8*CHARS_PER_WORD-1:0]                display_out,
    output logic [NUM_WORDS-1:0]                       led_out,
    output logic [$clog2(NUM_WORDS)-1:0]               word_index,
    output logic [$clog2(CHARS_PER_WORD+1)-1:0]        cursor_pos,
    output logic                                       dirty
);
    localparam int unsigned IW  = $clog2(NUM_WORDS);
    localparam int unsigned CW  = $clog2(CHARS_PER_WORD+1);
    localparam int unsigned WB  = 8*CHARS_PER_WORD;
    localparam int unsigned BCW = (BLINK_COUNTS > 1) ? $clog2(BLINK_COUNTS) : 1;

    typedef enum logic [2:0] {
        ACT_NONE, ACT_LOAD, ACT_SAVE, ACT_NEXT, ACT_PREV, ACT_CHAR, ACT_BKSP, ACT_DEL
    } action_t;

    logic [WB-1:0]  sentence [NUM_WORDS];
    logic [CW-1:0]  cursors  [NUM_WORDS];
    logic [WB-1:0]  work_word;
    logic [CW-1:0]  work_cursor;
    logic [BCW-1:0] blink_cnt;
    logic           blink_phase;

    action_t        act;
    logic           nav_move;
    logic [IW-1:0]  nav_target;
    logic [WB-1:0]  preset_words [NUM_WORDS];
    logic [CW-1:0]  preset_curs  [NUM_WORDS];

    function automatic logic is_char(input logic [7:0] c);
        case (c)
            8'h1C, 8'h24, 8'h43, 8'h44, 8'h3C, 8'h32, 8'h21, 8'h23, 8'h2B,
            8'h34, 8'h33, 8'h4B, 8'h31, 8'h4D, 8'h2D, 8'h1B, 8'h2C: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NUM_WORDS-1:0] led_for(input logic [IW-1:0] idx);
        return {1'b1, {(NUM_WORDS-1){1'b0}}} >> idx;
    endfunction

    // Unpack presets (word 0 in the MSBs) and clamp out-of-range cursors.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            preset_words[w] = preset_sentence[(NUM_WORDS-w)*WB-1 -: WB];
            preset_curs[w]  = preset_cursors[(NUM_WORDS-w)*CW-1 -: CW];
            if (preset_curs[w] > CW'(CHARS_PER_WORD))
                preset_curs[w] = CW'(CHARS_PER_WORD);
        end
    end

    // Buttons and their key aliases merge into one event; highest priority wins.
    always_comb begin
        act = ACT_NONE;
        if (!enable)
            act = ACT_NONE;
        else if (load || (key_valid && key_code == 8'h72))
            act = ACT_LOAD;
        else if (save || (key_valid && key_code == 8'h75))
            act = ACT_SAVE;
        else if (next_word || (key_valid && key_code == 8'h74))
            act = ACT_NEXT;
        else if (prev_word || (key_valid && key_code == 8'h6B))
            act = ACT_PREV;
        else if (key_valid && is_char(key_code))
            act = ACT_CHAR;
        else if (key_valid && key_code == 8'h66)
            act = ACT_BKSP;
        else if (key_valid && key_code == 8'h71)
            act = ACT_DEL;
    end

    always_comb begin
        nav_move   = 1'b0;
        nav_target = word_index;
        if (act == ACT_NEXT) begin
            if (word_index != IW'(NUM_WORDS-1)) begin
                nav_move   = 1'b1;
                nav_target = word_index + IW'(1);
            end
`ifdef SENTENCE_EDITOR_WRAP_EN
            else begin
                nav_move   = 1'b1;
                nav_target = '0;
            end
`endif
        end else if (act == ACT_PREV) begin
            if (word_index != '0) begin
                nav_move   = 1'b1;
                nav_target = word_index - IW'(1);
            end
`ifdef SENTENCE_EDITOR_WRAP_EN
            else begin
                nav_move   = 1'b1;
                nav_target = IW'(NUM_WORDS-1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                sentence[w] <= '0;
                cursors[w]  <= '0;
            end
            work_word   <= '0;
            work_cursor <= '0;
            word_index  <= '0;
            led_out     <= led_for('0);
            dirty       <= 1'b0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                        sentence[w] <= preset_words[w];
                        cursors[w]  <= preset_curs[w];
                    end
                    word_index  <= '0;
                    led_out     <= led_for('0);
                    work_word   <= preset_words[0];
                    work_cursor <= preset_curs[0];
                    dirty       <= 1'b0;
                end
                ACT_SAVE: begin
                    sentence[word_index] <= work_word;
                    cursors[word_index]  <= work_cursor;
                    dirty                <= 1'b0;
                end
                ACT_NEXT, ACT_PREV: begin
                    if (nav_move) begin
                        word_index  <= nav_target;
                        led_out     <= led_for(nav_target);
                        work_word   <= sentence[nav_target];
                        work_cursor <= cursors[nav_target];
                        dirty       <= 1'b0;
                    end
                end
                ACT_CHAR: begin
                    if (work_cursor < CW'(CHARS_PER_WORD)) begin
                        for (int unsigned i = 0; i < CHARS_PER_WORD; i++)
                            if (work_cursor == CW'(i))
                                work_word[WB-1-8*i -: 8] <= key_code;
                        work_cursor <= work_cursor + CW'(1);
                        dirty       <= 1'b1;
                    end
                end
                ACT_BKSP: begin
                    if (work_cursor != '0) begin
                        for (int unsigned i = 0; i < CHARS_PER_WORD; i++)
                            if (work_cursor == CW'(i+1))
                                work_word[WB-1-8*i -: 8] <= 8'h00;
                        work_cursor <= work_cursor - CW'(1);
                        dirty       <= 1'b1;
                    end
                end
                ACT_DEL: begin
                    if (work_cursor < CW'(CHARS_PER_WORD)) begin
                        for (int unsigned i = 0; i < CHARS_PER_WORD; i++)
                            if (work_cursor == CW'(i))
                                work_word[WB-1-8*i -: 8] <= 8'h00;
                        dirty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Blink timebase keeps running while the editor is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BCW'(BLINK_COUNTS-1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BCW'(1);
        end
    end

    always_comb begin
        display_out = work_word;
        if (blink_phase)
            for (int unsigned i = 0; i < CHARS_PER_WORD; i++)
                if (work_cursor == CW'(i))
                    display_out[WB-1-8*i -: 8] = work_word[WB-1-8*i -: 8] | CURSOR_CODE;
    end

    assign cursor_pos = work_cursor;

endmodule
